// File: rtl/ofdm_mod.sv
// ofdm_mod: writes one frequency-domain OFDM frame (pilots, BPSK data, zero bins) into a BSRAM for the IFFT.
// Define OFDM_MOD_HERMITIAN_EN to also write conjugate-mirrored bins so the IFFT output is purely real.
module ofdm_mod #(
    parameter int          FFT_N     = 256,
    parameter logic [15:0] AMPLITUDE = 16'h4000,
    parameter logic [10:0] BASE_ADDR = 11'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [95:0] data,
    output logic        busy,
    output logic        done,
    output logic        ce,
    output logic        wre,
    output logic [10:0] ad,
    output logic [31:0] din
);
    localparam int              KW      = $clog2(FFT_N);
    localparam logic [15:0]     NEG_AMP = ~AMPLITUDE + 16'd1;
    localparam logic [KW-1:0]   K_LAST  = KW'(FFT_N - 1);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d, nk;
    logic [6:0]    j_q, j_d, j_nx;
    logic [95:0]   payload_q, payload_d;
    logic          busy_q, busy_d, done_q, done_d, ce_q, ce_d, wre_q, wre_d;
    logic [10:0]   ad_q, ad_d;
    logic [31:0]   din_q, din_d;
    logic          last, accept, issue, pilot_bin, data_bin, bit_b;
    logic [15:0]   re;

    function automatic logic is_pilot(input logic [KW-1:0] x);
        return x == KW'(21) || x == KW'(22) || x == KW'(55) || x == KW'(88) || x == KW'(121);
    endfunction

    function automatic logic in_band(input logic [KW-1:0] x);
        return x >= KW'(21) && x <= KW'(121);
    endfunction

    // Outputs are registered, so each cycle computes the bin that appears on the port next cycle.
    assign last   = k_q == K_LAST;
    assign nk     = k_q + KW'(1);
    assign accept = state_q != WRITE && start;
    assign issue  = state_q == WRITE && !last;
    assign bit_b  = payload_q[j_q ^ 7'd7];

`ifdef OFDM_MOD_HERMITIAN_EN
    logic [KW-1:0] mk;
    logic          mirror;
    assign mk        = -nk;
    assign mirror    = nk >= KW'(FFT_N - 121) && nk <= KW'(FFT_N - 21);
    assign pilot_bin = mirror ? is_pilot(mk) : is_pilot(nk);
    assign data_bin  = mirror ? !is_pilot(mk) : in_band(nk) && !is_pilot(nk);
    // Mirror side walks the payload backwards, starting from the last data bit.
    assign j_nx      = nk == KW'(FFT_N - 121) ? 7'd95 : !data_bin ? j_q : mirror ? j_q - 7'd1 : j_q + 7'd1;
`else
    assign pilot_bin = is_pilot(nk);
    assign data_bin  = in_band(nk) && !is_pilot(nk);
    assign j_nx      = data_bin ? j_q + 7'd1 : j_q;
`endif

    assign re = pilot_bin ? AMPLITUDE : data_bin ? (bit_b ? AMPLITUDE : NEG_AMP) : 16'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            k_q       <= '0;
            j_q       <= '0;
            payload_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ce_q      <= 1'b0;
            wre_q     <= 1'b0;
            ad_q      <= '0;
            din_q     <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            j_q       <= j_d;
            payload_q <= payload_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ce_q      <= ce_d;
            wre_q     <= wre_d;
            ad_q      <= ad_d;
            din_q     <= din_d;
        end
    end

    // DONE also accepts start so back-to-back frames have the done cycle as their only gap.
    always_comb begin
        state_d = state_q == WRITE ? (last ? DONE : WRITE) : (start ? WRITE : IDLE);
    end

    // Bin 0 is never a pilot, data or mirror bin, so the first write is always zero.
    always_comb begin
        payload_d = accept ? data : payload_q;
        k_d       = accept ? '0 : issue ? nk : k_q;
        j_d       = accept ? '0 : issue ? j_nx : j_q;
        ce_d      = accept || issue;
        wre_d     = accept || issue;
        busy_d    = accept || issue;
        done_d    = state_q == WRITE && last;
        ad_d      = accept ? BASE_ADDR : issue ? BASE_ADDR + 11'(nk) : ad_q;
        din_d     = accept ? 32'h0 : issue ? {re, 16'h0} : din_q;
    end

    assign busy = busy_q;
    assign done = done_q;
    assign ce   = ce_q;
    assign wre  = wre_q;
    assign ad   = ad_q;
    assign din  = din_q;
endmodule

// File: tb/tb_ofdm_mod.sv
// tb_ofdm_mod: table spot checks, random frames against a bin-counting model, back-to-back and mid-frame reset.
module tb_ofdm_mod;
    localparam int          FFT_N = 256;
    localparam logic [15:0] AMP   = 16'h4000;
    localparam logic [15:0] NEG   = 16'hC000;
    localparam logic [10:0] BASE  = 11'd0;
    localparam logic [95:0] D1    = 96'h55_0123456789ABCDEF0123_55;

    logic        clk = 1'b0, rst, start;
    logic [95:0] data;
    logic        busy, done, ce, wre;
    logic [10:0] ad;
    logic [31:0] din;

    int pass_n = 0, total_n = 0;
    logic [31:0] got [2][FFT_N];
    int nw [2];
    int done_at [2];

    typedef struct {
        logic [95:0] d;
        int          k;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [13];

    always #5 clk = ~clk;

    ofdm_mod #(.FFT_N(FFT_N), .AMPLITUDE(AMP), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .start(start), .data(data), .busy(busy), .done(done),
        .ce(ce), .wre(wre), .ad(ad), .din(din)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: a data bin's payload index is the number of non-pilot band bins below it.
    function automatic logic [15:0] model(input logic [95:0] p, input int k);
        int j = 0;
        int kk = k;
`ifdef OFDM_MOD_HERMITIAN_EN
        if (k >= FFT_N - 121 && k <= FFT_N - 21) kk = FFT_N - k;
`endif
        if (kk inside {21, 22, 55, 88, 121}) return AMP;
        if (kk < 21 || kk > 121) return 16'h0;
        for (int i = 21; i < kk; i++) if (!(i inside {21, 22, 55, 88, 121})) j++;
        return p[j ^ 7] ? AMP : NEG;
    endfunction

    task automatic capture(input int ncyc, input int chg_at, input logic [95:0] chg_d);
        int f = 0, gap = 0, idx;
        logic prev_ce = 1'b0;
        for (int a = 0; a < 2; a++) begin
            nw[a] = 0;
            done_at[a] = -1;
            for (int b = 0; b < FFT_N; b++) got[a][b] = 'x;
        end
        for (int c = 1; c <= ncyc; c++) begin
            if (c == chg_at) data = chg_d;
            if (ce && wre) begin
                if (f > 0 && !prev_ce) check("gap", 64'(gap), 64'd1);
                if (f < 2) begin
                    check("ad_seq", 64'(ad), 64'(BASE) + 64'(nw[f]));
                    check("busy_w", 64'(busy), 64'd1);
                    idx = int'(ad - BASE);
                    if (idx < FFT_N) got[f][idx] = din;
                    nw[f]++;
                end
                gap = 0;
            end else begin
                gap++;
                if (done) begin
                    if (f < 2) done_at[f] = c;
                    f++;
                end
            end
            prev_ce = ce;
            step();
        end
    endtask

    task automatic verify(input int f, input logic [95:0] d, input int exp_done, input string tag);
        check($sformatf("%s nwrites", tag), 64'(nw[f]), 64'(FFT_N));
        check($sformatf("%s done_cycle", tag), 64'(done_at[f]), 64'(exp_done));
        for (int k = 0; k < FFT_N; k++)
            check($sformatf("%s bin %0d", tag, k), 64'(got[f][k]), 64'({model(d, k), 16'h0}));
    endtask

    task automatic run_frame(input logic [95:0] d);
        start = 1'b1;
        data = d;
        step();
        start = 1'b0;
        capture(FFT_N + 4, 0, '0);
    endtask

    initial begin
        int w, cnt;
        logic [95:0] d, d2;
        tbl[0]  = '{D1, 21, 32'h4000_0000};
        tbl[1]  = '{D1, 22, 32'h4000_0000};
        tbl[2]  = '{D1, 23, 32'hC000_0000};
        tbl[3]  = '{D1, 24, 32'h4000_0000};
        tbl[4]  = '{D1, 0, 32'h0};
        tbl[5]  = '{D1, 122, 32'h0};
        tbl[6]  = '{D1, 120, 32'h4000_0000};
        tbl[7]  = '{{96{1'b1}}, 23, 32'h4000_0000};
        tbl[8]  = '{{96{1'b1}}, 120, 32'h4000_0000};
        tbl[9]  = '{96'h0, 23, 32'hC000_0000};
        tbl[10] = '{96'h0, 55, 32'h4000_0000};
        tbl[11] = '{96'h0, 128, 32'h0};
        tbl[12] = '{96'h0, 255, 32'h0};

        rst = 1'b1;
        start = 1'b0;
        data = '0;
        repeat (3) step();
        check("reset_outs", 64'({ce, wre, busy, done, ad, din}), 64'd0);
        rst = 1'b0;
        step();
        check("idle_outs", 64'({ce, wre, busy, done}), 64'd0);

        for (int i = 0; i < 13; i++) begin
            if (i == 0 || tbl[i].d !== tbl[i-1].d) begin
                run_frame(tbl[i].d);
                verify(0, tbl[i].d, FFT_N + 1, $sformatf("tbl%0d", i));
            end
            check($sformatf("tbl%0d spot %0d", i, tbl[i].k), 64'(got[0][tbl[i].k]), 64'(tbl[i].exp));
        end

        for (int r = 0; r < 4; r++) begin
            d = {$urandom, $urandom, $urandom};
            run_frame(d);
            verify(0, d, FFT_N + 1, $sformatf("rnd%0d", r));
        end

        // start held: frames repeat with only the done cycle between them; data changes mid-frame
        d  = {$urandom, $urandom, $urandom};
        d2 = ~d;
        start = 1'b1;
        data = d;
        step();
        capture(600, 100, d2);
        start = 1'b0;
        verify(0, d, FFT_N + 1, "b2b0");
        verify(1, d2, 2 * (FFT_N + 1), "b2b1");
        w = 0;
        while (!done && w < 400) begin step(); w++; end
        check("b2b_drain", 64'(done), 64'd1);
        step();

        // reset mid-frame
        start = 1'b1;
        data = D1;
        step();
        start = 1'b0;
        w = 0;
        while (!(ce && ad == BASE + 11'd60) && w < 100) begin step(); w++; end
        check("reach_k60", 64'(ce && ad == BASE + 11'd60), 64'd1);
        rst = 1'b1;
        step();
        check("mid_rst_outs", 64'({ce, wre, busy, done, ad, din}), 64'd0);
        step();
        rst = 1'b0;
        cnt = 0;
        repeat (300) begin
            if (ce || done) cnt++;
            step();
        end
        check("quiet_after_rst", 64'(cnt), 64'd0);
        d = {$urandom, $urandom, $urandom};
        run_frame(d);
        verify(0, d, FFT_N + 1, "post_rst");

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
